// File: rtl/psum_arb_if.sv
// Bundle between the PE result channels, the psum output arbiter and the
// downstream bit packer. The channel side drives requests, bits and the
// stall back-pressure; the arbiter side answers with grant/ready and the
// serialized bit stream.
interface psum_arb_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] ch_req;
    logic [NUM_CH-1:0] ch_valid;
    logic [NUM_CH-1:0] ch_data;
    logic [NUM_CH-1:0] ch_done;
    logic [NUM_CH-1:0] ch_grant;
    logic [NUM_CH-1:0] ch_ready;
    logic              stall;
    logic              pk_valid;
    logic              pk_data;
    logic              pk_layer_finish;

    // Channel/environment side
    modport master (
        output ch_req, ch_valid, ch_data, ch_done, stall,
        input  ch_grant, ch_ready, pk_valid, pk_data, pk_layer_finish
    );

    // Arbiter side
    modport slave (
        input  ch_req, ch_valid, ch_data, ch_done, stall,
        output ch_grant, ch_ready, pk_valid, pk_data, pk_layer_finish
    );
endinterface

// File: rtl/psum_out_arbiter.sv
// Round-robin owner of the shared psum output packer. One channel at a time
// streams a whole layer of psum bits; the layer is closed with a one-cycle
// pk_layer_finish pulse, followed by a one-cycle gap before re-arbitration.
// Optional feature: define PSUM_ARB_BITCNT_EN to expose a saturating
// per-layer accepted-bit counter on bit_count.
module psum_out_arbiter #(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    psum_arb_if.slave            bus,
    output logic                 busy
`ifdef PSUM_ARB_BITCNT_EN
    ,
    output logic [CNT_WIDTH-1:0] bit_count
`endif
);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {IDLE, SERVE, DRAIN, FINISH, GAP} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] gidx_q;
    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_found;
    logic             pk_valid_q;
    logic             pk_data_q;
    logic             accept;
    logic             done_acc;
    logic             start;
    logic             nonempty;

    // Grant is owned only while serving; it drops the cycle after done.
    assign bus.ch_grant = (state_q == SERVE)
                        ? ({{(NUM_CH-1){1'b0}}, 1'b1} << gidx_q) : '0;
    assign bus.ch_ready = bus.ch_grant & {NUM_CH{~bus.stall}};

    // Only the granted lane is looked at; other lanes are don't-care.
    assign accept   = (state_q == SERVE) & bus.ch_valid[gidx_q] & ~bus.stall;
    assign done_acc = (state_q == SERVE) & bus.ch_done[gidx_q]  & ~bus.stall;
    assign start    = (state_q == IDLE) & sel_found;

    assign bus.pk_valid        = pk_valid_q;
    assign bus.pk_data         = pk_data_q;
    assign bus.pk_layer_finish = (state_q == FINISH) & nonempty;
    assign busy                = (state_q != IDLE);

    // Round-robin pick: first requester strictly after the last grant.
    always_comb begin
        int k;
        k         = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            k = (int'(last_q) + i) % NUM_CH;
            if (!sel_found && bus.ch_req[k]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(k);
            end
        end
    end

    // Layer sequencing: serve until done, then drain/finish/gap back to idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sel_found) state_d = SERVE;
            SERVE:   if (done_acc)  state_d = DRAIN;
            DRAIN:   state_d = FINISH;
            FINISH:  state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, owner index, round-robin pointer and the registered bit output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gidx_q     <= '0;
            last_q     <= IDX_W'(NUM_CH - 1);
            pk_valid_q <= 1'b0;
            pk_data_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pk_valid_q <= accept;
            if (accept) pk_data_q <= bus.ch_data[gidx_q];
            if (start) begin
                gidx_q <= sel_idx;
                last_q <= sel_idx;
            end
        end
    end

`ifdef PSUM_ARB_BITCNT_EN
    logic [CNT_WIDTH-1:0] cnt_q;

    // Accepted bits of the current layer; cleared on grant, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     cnt_q <= '0;
        else if (start)                 cnt_q <= '0;
        else if (accept && cnt_q != '1) cnt_q <= cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end

    assign bit_count = cnt_q;
    assign nonempty  = (cnt_q != '0);
`else
    logic nonempty_q;

    // Remembers whether this layer forwarded anything, to gate the finish pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      nonempty_q <= 1'b0;
        else if (start)  nonempty_q <= 1'b0;
        else if (accept) nonempty_q <= 1'b1;
    end

    assign nonempty = nonempty_q;
`endif
endmodule
